ctrl_unit: RTL and testbench
============================

CTRL_UNIT -- requirements
Module: ctrl_unit

Interface
REQ-001 Parameter AUTO_RUN, default 0: when 1, IDLE exits without waiting for run.
REQ-002 CLK  in  1  sole clock; all state updates on rising edge.
REQ-003 RSTN  in  1  reset, synchronous, active-low.
REQ-004 run  in  1  level; start fetching from IDLE.
REQ-005 IR  in  16  instruction register contents.
REQ-006 sc  out  3  sequence counter, T0..T6 = 0..6.
REQ-007 bus_sel  out  3  1 AR, 2 PC, 3 DR, 4 AC, 5 IR, 7 MEM, 0 none.
REQ-008 ar_ld, ar_inr, pc_ld, pc_inr, pc_clr, dr_ld, dr_inr, ac_ld, ac_clr, ac_inr, ir_ld, e_clr, e_cmp, mem_rd, mem_wr  out  1 each  register/memory strobes.
REQ-009 alu_op  out  3  0 AND, 1 ADD, 2 PASS_DR, 3 CMA, 4 SHR, 5 SHL; qualified by ac_ld.
REQ-010 ISZ, SPA, SNA, SZA, SZE  out  1 each  skip-condition strobes to the PC register.
REQ-011 halted  out  1  high in HALT.

Function
REQ-012 States: IDLE, RUN, HALT; strobes are combinational decode of state, sc, latched I bit and IR; all strobes 0 outside RUN.
REQ-013 IDLE->RUN when run=1 or AUTO_RUN=1, sc=0; RUN->HALT on HLT at T3; HALT exits only by reset.
REQ-014 T0: bus_sel=PC, ar_ld.
REQ-015 T1: bus_sel=MEM, mem_rd, ir_ld, pc_inr.
REQ-016 T2: bus_sel=IR, ar_ld (AR<-IR[11:0]); latch I<=IR[15]; opcode D=IR[14:12] decoded this cycle.
REQ-017 T3, D=7, I=0: register-reference; one strobe per set IR bit: b11 ac_clr, b10 e_clr, b9 ac_ld+CMA, b8 e_cmp, b7 ac_ld+SHR, b6 ac_ld+SHL, b5 ac_inr, b4 SPA, b3 SNA, b2 SZA, b1 SZE, b0 HALT; sc<=0.
REQ-018 Multiple IR bits set at T3: all strobes asserted together; if more than one of b9/b7/b6 set, priority CMA > SHR > SHL.
REQ-019 T3, D=7, I=1 (I/O): no strobes, sc<=0.
REQ-020 T3, D!=7, I=1: bus_sel=MEM, mem_rd, ar_ld; I=0: no strobes; both advance to T4.
REQ-021 AND/ADD/LDA (D=0/1/2): T4 bus_sel=MEM, mem_rd, dr_ld; T5 ac_ld with alu_op AND/ADD/PASS_DR, sc<=0.
REQ-022 STA (D=3): T4 bus_sel=AC, mem_wr, sc<=0.
REQ-023 BUN (D=4): T4 bus_sel=AR, pc_ld, sc<=0.
REQ-024 BSA (D=5): T4 bus_sel=PC, mem_wr, ar_inr; T5 bus_sel=AR, pc_ld, sc<=0.
REQ-025 ISZ (D=6): T4 bus_sel=MEM, mem_rd, dr_ld; T5 dr_inr; T6 bus_sel=DR, mem_wr, ISZ strobe, sc<=0.
REQ-026 Never assert pc_inr, pc_ld or pc_clr together with any skip strobe.
REQ-027 Per cycle: at most one bus_sel source and at most one of mem_rd/mem_wr.
REQ-028 sc increments each RUN cycle except when cleared per above; sc never exceeds 6.

Reset
REQ-029 RSTN low at an edge: state<=IDLE, sc<=0, I<=0.
REQ-030 pc_clr = ~RSTN combinationally, so PC clears on the same edge.
REQ-031 While RSTN low, all other strobes are 0 and halted=0.
REQ-032 Reset mid-instruction abandons it; no memory write is issued in the reset cycle.

Structure
REQ-033 Shared package holds: state encoding, bus_sel codes, alu_op codes, opcode values D0..D7, register-reference bit positions.
REQ-034 One sub-module, seq_counter: 3-bit counter with inr/clr and synchronous active-low reset.

Verification
REQ-035 Reset, then run=1, IR=0x2005 (LDA direct): T0..T5 strobes per REQ-014/015/016/021; ac_ld with PASS_DR at T5; sc returns to 0.
REQ-036 IR=0xC010 (BUN indirect): T3 mem_rd+ar_ld; T4 pc_ld with bus_sel=AR; 5 cycles total.
REQ-037 IR=0x6020 (ISZ): dr_inr at T5; T6 ISZ=1, mem_wr=1, pc_inr=0.
REQ-038 IR=0x7014 (SPA+SZA): T3 SPA=SZA=1, pc_inr=0, sc<=0 at next edge.
REQ-039 IR=0x7001 (HLT): halted=1 from next cycle; strobes stay 0 with run=1; RSTN low clears halted and pulses pc_clr.
REQ-040 RSTN low during T4 of STA (IR=0x3008): mem_wr=0 in the reset cycle; IDLE, sc=0 afterwards.

Source files
------------

// File: rtl/ctrl_unit_pkg.sv
// Shared encodings for the basic-computer control unit: states, bus sources,
// ALU ops, opcodes and register-reference bit positions.
package ctrl_unit_pkg;

  localparam int unsigned SC_W  = 3;
  localparam int unsigned IR_W  = 16;
  localparam int unsigned SEL_W = 3;
  localparam int unsigned ALU_W = 3;
  localparam int unsigned OP_W  = 3;

  localparam int unsigned IR_I_BIT = 15;
  localparam int unsigned IR_OP_HI = 14;
  localparam int unsigned IR_OP_LO = 12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  localparam logic [SEL_W-1:0] BUS_NONE = 3'd0;
  localparam logic [SEL_W-1:0] BUS_AR   = 3'd1;
  localparam logic [SEL_W-1:0] BUS_PC   = 3'd2;
  localparam logic [SEL_W-1:0] BUS_DR   = 3'd3;
  localparam logic [SEL_W-1:0] BUS_AC   = 3'd4;
  localparam logic [SEL_W-1:0] BUS_IR   = 3'd5;
  localparam logic [SEL_W-1:0] BUS_MEM  = 3'd7;

  localparam logic [ALU_W-1:0] ALU_AND     = 3'd0;
  localparam logic [ALU_W-1:0] ALU_ADD     = 3'd1;
  localparam logic [ALU_W-1:0] ALU_PASS_DR = 3'd2;
  localparam logic [ALU_W-1:0] ALU_CMA     = 3'd3;
  localparam logic [ALU_W-1:0] ALU_SHR     = 3'd4;
  localparam logic [ALU_W-1:0] ALU_SHL     = 3'd5;

  localparam logic [OP_W-1:0] OP_AND = 3'd0;
  localparam logic [OP_W-1:0] OP_ADD = 3'd1;
  localparam logic [OP_W-1:0] OP_LDA = 3'd2;
  localparam logic [OP_W-1:0] OP_STA = 3'd3;
  localparam logic [OP_W-1:0] OP_BUN = 3'd4;
  localparam logic [OP_W-1:0] OP_BSA = 3'd5;
  localparam logic [OP_W-1:0] OP_ISZ = 3'd6;
  localparam logic [OP_W-1:0] OP_REG = 3'd7;

  localparam int unsigned RB_CLA = 11;
  localparam int unsigned RB_CLE = 10;
  localparam int unsigned RB_CMA = 9;
  localparam int unsigned RB_CME = 8;
  localparam int unsigned RB_CIR = 7;
  localparam int unsigned RB_CIL = 6;
  localparam int unsigned RB_INC = 5;
  localparam int unsigned RB_SPA = 4;
  localparam int unsigned RB_SNA = 3;
  localparam int unsigned RB_SZA = 2;
  localparam int unsigned RB_SZE = 1;
  localparam int unsigned RB_HLT = 0;

  localparam logic [SC_W-1:0] T0 = 3'd0;
  localparam logic [SC_W-1:0] T1 = 3'd1;
  localparam logic [SC_W-1:0] T2 = 3'd2;
  localparam logic [SC_W-1:0] T3 = 3'd3;
  localparam logic [SC_W-1:0] T4 = 3'd4;
  localparam logic [SC_W-1:0] T5 = 3'd5;
  localparam logic [SC_W-1:0] T6 = 3'd6;

  // AC-modifying register-reference ops share one ALU port: CMA > SHR > SHL
  function automatic logic [ALU_W-1:0] regref_alu(input logic [IR_W-1:0] ir);
    logic [ALU_W-1:0] op;
    op = ALU_AND;
    if (ir[RB_CMA])      op = ALU_CMA;
    else if (ir[RB_CIR]) op = ALU_SHR;
    else if (ir[RB_CIL]) op = ALU_SHL;
    return op;
  endfunction

endpackage

// File: rtl/ctrl_unit_if.sv
// Control-unit bundle: run/IR inputs and all datapath/memory strobes.
interface ctrl_unit_if;
  import ctrl_unit_pkg::*;

  logic             run;
  logic [IR_W-1:0]  IR;
  logic [SC_W-1:0]  sc;
  logic [SEL_W-1:0] bus_sel;
  logic [ALU_W-1:0] alu_op;
  logic ar_ld, ar_inr, pc_ld, pc_inr, pc_clr, dr_ld, dr_inr;
  logic ac_ld, ac_clr, ac_inr, ir_ld, e_clr, e_cmp, mem_rd, mem_wr;
  logic ISZ, SPA, SNA, SZA, SZE;
  logic halted;

  modport master (
    input  run, IR,
    output sc, bus_sel, alu_op,
    output ar_ld, ar_inr, pc_ld, pc_inr, pc_clr, dr_ld, dr_inr,
    output ac_ld, ac_clr, ac_inr, ir_ld, e_clr, e_cmp, mem_rd, mem_wr,
    output ISZ, SPA, SNA, SZA, SZE, halted
  );

  modport slave (
    output run, IR,
    input  sc, bus_sel, alu_op,
    input  ar_ld, ar_inr, pc_ld, pc_inr, pc_clr, dr_ld, dr_inr,
    input  ac_ld, ac_clr, ac_inr, ir_ld, e_clr, e_cmp, mem_rd, mem_wr,
    input  ISZ, SPA, SNA, SZA, SZE, halted
  );
endinterface

// File: rtl/ctrl_unit_seq_counter.sv
// 3-bit timing-step counter; clear wins over increment.
module seq_counter
  import ctrl_unit_pkg::*;
(
  input  logic            CLK,
  input  logic            RSTN,
  input  logic            inr,
  input  logic            clr,
  output logic [SC_W-1:0] cnt
);

  always_ff @(posedge CLK) begin
    if (!RSTN)     cnt <= '0;
    else if (clr)  cnt <= '0;
    else if (inr)  cnt <= cnt + SC_W'(1);
  end

endmodule

// File: rtl/ctrl_unit.sv
// Hardwired control unit: IDLE/RUN/HALT sequencing plus per-step strobe decode
// of the fetch, indirect and execute phases.
module ctrl_unit
  import ctrl_unit_pkg::*;
#(
  parameter bit AUTO_RUN = 1'b0
) (
  input logic         CLK,
  input logic         RSTN,
  ctrl_unit_if.master cu
);

  state_t          state;
  logic            i_bit;
  logic [SC_W-1:0] sc;
  logic [OP_W-1:0] d;
  logic            sc_clr_c;
  logic            halt_c;

  assign d         = cu.IR[IR_OP_HI:IR_OP_LO];
  assign cu.sc     = sc;
  assign cu.pc_clr = ~RSTN;
  assign cu.halted = RSTN && (state == ST_HALT);

  seq_counter u_seq_counter (
    .CLK  (CLK),
    .RSTN (RSTN),
    .inr  (state == ST_RUN),
    .clr  (sc_clr_c),
    .cnt  (sc)
  );

  // State and indirect-bit latch; I is captured while IR is on the bus at T2
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state <= ST_IDLE;
      i_bit <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: if (cu.run || AUTO_RUN) state <= ST_RUN;
        ST_RUN: begin
          if (sc == T2) i_bit <= cu.IR[IR_I_BIT];
          if (halt_c)   state <= ST_HALT;
        end
        ST_HALT: state <= ST_HALT;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    cu.bus_sel = BUS_NONE;
    cu.alu_op  = ALU_AND;
    cu.ar_ld   = 1'b0;
    cu.ar_inr  = 1'b0;
    cu.pc_ld   = 1'b0;
    cu.pc_inr  = 1'b0;
    cu.dr_ld   = 1'b0;
    cu.dr_inr  = 1'b0;
    cu.ac_ld   = 1'b0;
    cu.ac_clr  = 1'b0;
    cu.ac_inr  = 1'b0;
    cu.ir_ld   = 1'b0;
    cu.e_clr   = 1'b0;
    cu.e_cmp   = 1'b0;
    cu.mem_rd  = 1'b0;
    cu.mem_wr  = 1'b0;
    cu.ISZ     = 1'b0;
    cu.SPA     = 1'b0;
    cu.SNA     = 1'b0;
    cu.SZA     = 1'b0;
    cu.SZE     = 1'b0;
    sc_clr_c   = 1'b0;
    halt_c     = 1'b0;
    if (RSTN && state == ST_RUN) begin
      unique case (sc)
        T0: begin
          cu.bus_sel = BUS_PC;
          cu.ar_ld   = 1'b1;
        end
        T1: begin
          cu.bus_sel = BUS_MEM;
          cu.mem_rd  = 1'b1;
          cu.ir_ld   = 1'b1;
          cu.pc_inr  = 1'b1;
        end
        T2: begin
          cu.bus_sel = BUS_IR;
          cu.ar_ld   = 1'b1;
        end
        T3: begin
          if (d == OP_REG) begin
            sc_clr_c = 1'b1;
            // I/O instructions (I=1) are recognised but issue nothing
            if (!i_bit) begin
              cu.ac_clr = cu.IR[RB_CLA];
              cu.e_clr  = cu.IR[RB_CLE];
              cu.ac_ld  = cu.IR[RB_CMA] | cu.IR[RB_CIR] | cu.IR[RB_CIL];
              cu.alu_op = regref_alu(cu.IR);
              cu.e_cmp  = cu.IR[RB_CME];
              cu.ac_inr = cu.IR[RB_INC];
              cu.SPA    = cu.IR[RB_SPA];
              cu.SNA    = cu.IR[RB_SNA];
              cu.SZA    = cu.IR[RB_SZA];
              cu.SZE    = cu.IR[RB_SZE];
              halt_c    = cu.IR[RB_HLT];
            end
          end else if (i_bit) begin
            cu.bus_sel = BUS_MEM;
            cu.mem_rd  = 1'b1;
            cu.ar_ld   = 1'b1;
          end
        end
        T4: begin
          unique case (d)
            OP_AND, OP_ADD, OP_LDA, OP_ISZ: begin
              cu.bus_sel = BUS_MEM;
              cu.mem_rd  = 1'b1;
              cu.dr_ld   = 1'b1;
            end
            OP_STA: begin
              cu.bus_sel = BUS_AC;
              cu.mem_wr  = 1'b1;
              sc_clr_c   = 1'b1;
            end
            OP_BUN: begin
              cu.bus_sel = BUS_AR;
              cu.pc_ld   = 1'b1;
              sc_clr_c   = 1'b1;
            end
            OP_BSA: begin
              cu.bus_sel = BUS_PC;
              cu.mem_wr  = 1'b1;
              cu.ar_inr  = 1'b1;
            end
            default: sc_clr_c = 1'b1;
          endcase
        end
        T5: begin
          unique case (d)
            OP_AND, OP_ADD, OP_LDA: begin
              cu.ac_ld  = 1'b1;
              cu.alu_op = (d == OP_AND) ? ALU_AND :
                          (d == OP_ADD) ? ALU_ADD : ALU_PASS_DR;
              sc_clr_c  = 1'b1;
            end
            OP_BSA: begin
              cu.bus_sel = BUS_AR;
              cu.pc_ld   = 1'b1;
              sc_clr_c   = 1'b1;
            end
            OP_ISZ:  cu.dr_inr = 1'b1;
            default: sc_clr_c  = 1'b1;
          endcase
        end
        T6: begin
          if (d == OP_ISZ) begin
            cu.bus_sel = BUS_DR;
            cu.mem_wr  = 1'b1;
            cu.ISZ     = 1'b1;
          end
          sc_clr_c = 1'b1;
        end
        default: sc_clr_c = 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_ctrl_unit.sv
// Bench for ctrl_unit: directed and random instructions compared cycle by cycle
// against a micro-operation plan built from the instruction set description.
module tb_ctrl_unit;

  logic CLK = 1'b0;
  logic RSTN;

  ctrl_unit_if cu ();

  ctrl_unit #(.AUTO_RUN(1'b0)) dut (
    .CLK  (CLK),
    .RSTN (RSTN),
    .cu   (cu)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [2:0] sc;
    logic [2:0] bus_sel;
    logic [2:0] alu_op;
    logic ar_ld, ar_inr, pc_ld, pc_inr, pc_clr, dr_ld, dr_inr;
    logic ac_ld, ac_clr, ac_inr, ir_ld, e_clr, e_cmp, mem_rd, mem_wr;
    logic isz, spa, sna, sza, sze, halted;
  } cyc_t;

  int   total = 0;
  int   bad   = 0;
  cyc_t plan_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic cyc_t blank(input int t);
    cyc_t c;
    c    = '0;
    c.sc = 3'(t);
    return c;
  endfunction

  function automatic cyc_t observe();
    cyc_t o;
    o.sc      = cu.sc;
    o.bus_sel = cu.bus_sel;
    o.alu_op  = cu.ac_ld ? cu.alu_op : 3'd0;
    o.ar_ld   = cu.ar_ld;   o.ar_inr = cu.ar_inr; o.pc_ld  = cu.pc_ld;
    o.pc_inr  = cu.pc_inr;  o.pc_clr = cu.pc_clr; o.dr_ld  = cu.dr_ld;
    o.dr_inr  = cu.dr_inr;  o.ac_ld  = cu.ac_ld;  o.ac_clr = cu.ac_clr;
    o.ac_inr  = cu.ac_inr;  o.ir_ld  = cu.ir_ld;  o.e_clr  = cu.e_clr;
    o.e_cmp   = cu.e_cmp;   o.mem_rd = cu.mem_rd; o.mem_wr = cu.mem_wr;
    o.isz     = cu.ISZ;     o.spa    = cu.SPA;    o.sna    = cu.SNA;
    o.sza     = cu.SZA;     o.sze    = cu.SZE;    o.halted = cu.halted;
    return o;
  endfunction

  // Micro-operation plan for one instruction, one entry per timing step
  task automatic plan(input logic [15:0] ir);
    cyc_t c;
    int   op;
    bit   ind;
    op  = int'(ir[14:12]);
    ind = ir[15];
    plan_q.delete();
    c = blank(0); c.bus_sel = 3'd2; c.ar_ld = 1'b1; plan_q.push_back(c);
    c = blank(1); c.bus_sel = 3'd7; c.mem_rd = 1'b1; c.ir_ld = 1'b1; c.pc_inr = 1'b1;
    plan_q.push_back(c);
    c = blank(2); c.bus_sel = 3'd5; c.ar_ld = 1'b1; plan_q.push_back(c);
    c = blank(3);
    if (op == 7) begin
      if (!ind) begin
        c.ac_clr = ir[11]; c.e_clr = ir[10]; c.e_cmp = ir[8]; c.ac_inr = ir[5];
        c.spa = ir[4]; c.sna = ir[3]; c.sza = ir[2]; c.sze = ir[1];
        c.ac_ld  = ir[9] | ir[7] | ir[6];
        c.alu_op = ir[9] ? 3'd3 : ir[7] ? 3'd4 : ir[6] ? 3'd5 : 3'd0;
      end
      plan_q.push_back(c);
      return;
    end
    if (ind) begin
      c.bus_sel = 3'd7; c.mem_rd = 1'b1; c.ar_ld = 1'b1;
    end
    plan_q.push_back(c);
    c = blank(4);
    case (op)
      0, 1, 2: begin
        c.bus_sel = 3'd7; c.mem_rd = 1'b1; c.dr_ld = 1'b1; plan_q.push_back(c);
        c = blank(5); c.ac_ld = 1'b1; c.alu_op = 3'(op); plan_q.push_back(c);
      end
      3: begin c.bus_sel = 3'd4; c.mem_wr = 1'b1; plan_q.push_back(c); end
      4: begin c.bus_sel = 3'd1; c.pc_ld = 1'b1; plan_q.push_back(c); end
      5: begin
        c.bus_sel = 3'd2; c.mem_wr = 1'b1; c.ar_inr = 1'b1; plan_q.push_back(c);
        c = blank(5); c.bus_sel = 3'd1; c.pc_ld = 1'b1; plan_q.push_back(c);
      end
      default: begin
        c.bus_sel = 3'd7; c.mem_rd = 1'b1; c.dr_ld = 1'b1; plan_q.push_back(c);
        c = blank(5); c.dr_inr = 1'b1; plan_q.push_back(c);
        c = blank(6); c.bus_sel = 3'd3; c.mem_wr = 1'b1; c.isz = 1'b1; plan_q.push_back(c);
      end
    endcase
  endtask

  // Entered #1 after a rising edge; leaves #1 after the next one
  task automatic expect_cycle(input string tag, input cyc_t want);
    cyc_t o;
    @(negedge CLK);
    o = observe();
    check(tag, 64'(o), 64'(want));
    check({tag, " rd_wr"}, 64'(o.mem_rd & o.mem_wr), 64'd0);
    check({tag, " pc_skip"},
          64'((o.pc_inr | o.pc_ld | o.pc_clr) & (o.isz | o.spa | o.sna | o.sza | o.sze)), 64'd0);
    @(posedge CLK);
    #1;
  endtask

  task automatic run_instr(input logic [15:0] ir, input int steps);
    int n;
    cu.IR = ir;
    plan(ir);
    n = (steps < plan_q.size()) ? steps : plan_q.size();
    for (int i = 0; i < n; i++)
      expect_cycle($sformatf("ir=%h T%0d", ir, i), plan_q[i]);
  endtask

  cyc_t rst_c;

  initial begin
    RSTN   = 1'b0;
    cu.run = 1'b0;
    cu.IR  = 16'h0000;
    @(posedge CLK);
    #1;
    rst_c = blank(0); rst_c.pc_clr = 1'b1;
    expect_cycle("reset", rst_c);
    RSTN = 1'b1;
    expect_cycle("idle_norun", blank(0));
    cu.run = 1'b1;
    expect_cycle("idle_run", blank(0));

    run_instr(16'h2005, 99);
    run_instr(16'hC010, 99);
    run_instr(16'h6020, 99);
    run_instr(16'h7014, 99);
    run_instr(16'h72C0, 99);
    run_instr(16'hF000, 99);
    run_instr(16'h5123, 99);
    run_instr(16'h8456, 99);

    for (int k = 0; k < 40; k++) begin
      logic [15:0] ir;
      int          cls;
      cls = int'($urandom_range(0, 3));
      ir  = 16'($urandom);
      if (cls == 0)      ir = {4'h7, 12'($urandom) & 12'hFFE};
      else if (cls == 1) ir[14:12] = 3'd7;
      else               ir[14:12] = 3'($urandom_range(0, 6));
      if (ir[14:12] == 3'd7 && !ir[15]) ir[0] = 1'b0;
      run_instr(ir, 99);
    end

    // Reset in the middle of a store: write must be suppressed
    run_instr(16'h3008, 4);
    RSTN  = 1'b0;
    rst_c = blank(4); rst_c.pc_clr = 1'b1;
    expect_cycle("sta_reset", rst_c);
    RSTN = 1'b1;
    expect_cycle("sta_after_reset", blank(0));

    run_instr(16'h7001, 99);
    rst_c = blank(0); rst_c.halted = 1'b1;
    for (int i = 0; i < 3; i++) expect_cycle($sformatf("halted%0d", i), rst_c);
    RSTN  = 1'b0;
    rst_c = blank(0); rst_c.pc_clr = 1'b1;
    expect_cycle("halt_reset", rst_c);
    RSTN = 1'b1;
    expect_cycle("halt_after_reset", blank(0));
    run_instr(16'h1003, 99);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
